// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
//   WB_XLEN / WB_AW : register data / address widths used by wb_req_t
//   GPR_ZERO        : hardwired-zero GPR address (writes to it are dropped)
//   SLOT_*          : index of each source in the slot array
package wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_AW     = 5;
  localparam int NUM_SLOTS = 4;

  localparam logic [WB_AW-1:0] GPR_ZERO = '0;

  localparam int SLOT_UART = 0;
  localparam int SLOT_ALU  = 1;
  localparam int SLOT_FPU  = 2;
  localparam int SLOT_MOV  = 3;

  typedef enum logic [2:0] {SRC_LOAD, SRC_UART, SRC_ALU, SRC_FPU, SRC_MOV} wb_src_e;

  typedef enum logic [1:0] {LD_IDLE, LD_WAIT, LD_FULL} ld_state_e;

  typedef struct packed {
    logic               full;
    logic [WB_AW-1:0]   addr;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its surroundings.
//   slave  : arbiter side (takes requests/load events, drives readies and write ports)
//   master : source / register-file side (the mirror image)
interface wb_arbiter_if #(
  parameter int XLEN = wb_pkg::WB_XLEN,
  parameter int AW   = wb_pkg::WB_AW
);

  logic            alu_valid,  alu_ready;
  logic [AW-1:0]   alu_addr;
  logic [XLEN-1:0] alu_data;
  logic            uart_valid, uart_ready;
  logic [AW-1:0]   uart_addr;
  logic [XLEN-1:0] uart_data;
  logic            fpu_valid,  fpu_ready;
  logic [AW-1:0]   fpu_addr;
  logic [XLEN-1:0] fpu_data;
  logic            mov_valid,  mov_ready;
  logic [AW-1:0]   mov_addr;
  logic [XLEN-1:0] mov_data;

  logic            ld_issue, ld_fpr, load_finish, ld_busy, ld_err;
  logic [AW-1:0]   ld_addr;
  logic [XLEN-1:0] rdata;

  logic            gpr_we, fpr_we, wgpr_finish, wfpr_finish;
  logic [AW-1:0]   gpr_waddr, fpr_waddr;
  logic [XLEN-1:0] gpr_wdata, fpr_wdata;

  modport slave (
    input  alu_valid, alu_addr, alu_data, uart_valid, uart_addr, uart_data,
           fpu_valid, fpu_addr, fpu_data, mov_valid, mov_addr, mov_data,
           ld_issue, ld_fpr, ld_addr, load_finish, rdata,
    output alu_ready, uart_ready, fpu_ready, mov_ready, ld_busy, ld_err,
           gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
           wgpr_finish, wfpr_finish
  );

  modport master (
    output alu_valid, alu_addr, alu_data, uart_valid, uart_addr, uart_data,
           fpu_valid, fpu_addr, fpu_data, mov_valid, mov_addr, mov_data,
           ld_issue, ld_fpr, ld_addr, load_finish, rdata,
    input  alu_ready, uart_ready, fpu_ready, mov_ready, ld_busy, ld_err,
           gpr_we, gpr_waddr, gpr_wdata, fpr_we, fpr_waddr, fpr_wdata,
           wgpr_finish, wfpr_finish
  );

endinterface

// File: rtl/wb_slot.sv
// One-entry request holding register.
//   valid/addr/data : incoming request, captured when the slot is empty
//   ready           : slot empty (no same-cycle bypass through a clearing slot)
//   clr             : request was granted this cycle, empty at the next edge
//   req             : held request (full/addr/data)
module wb_slot
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int AW   = WB_AW
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            valid,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] data,
  input  logic            clr,
  output logic            ready,
  output wb_req_t         req
);

  wb_req_t req_q, req_d;

  // clr only ever hits a full slot and capture only an empty one,
  // so the two never collide in the same cycle.
  always_comb begin
    req_d = req_q;
    if (clr) req_d.full = 1'b0;
    if (valid && !req_q.full) req_d = '{full: 1'b1, addr: addr, data: data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) req_q <= '0;
    else       req_q <= req_d;
  end

  assign ready = !req_q.full;
  assign req   = req_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback scheduler for the GPR and FPR register files.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : source requests (alu/uart -> GPR, fpu/mov -> FPR), load
//               issue/return, registered GPR/FPR write ports, finish pulses,
//               ld_busy and the sticky ld_err flag
// Each source owns a one-entry slot; the single outstanding load is tracked
// here. Each file picks one full slot per cycle by fixed priority and the
// winner is registered onto its write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int AW   = WB_AW
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);

  // ---------------- source slots ----------------
  logic [NUM_SLOTS-1:0]           s_valid, s_ready, s_clr;
  logic [NUM_SLOTS-1:0][AW-1:0]   s_addr;
  logic [NUM_SLOTS-1:0][XLEN-1:0] s_data;
  wb_req_t [NUM_SLOTS-1:0]        s_req;

  assign s_valid = {bus.mov_valid, bus.fpu_valid, bus.alu_valid, bus.uart_valid};
  assign s_addr  = {bus.mov_addr,  bus.fpu_addr,  bus.alu_addr,  bus.uart_addr};
  assign s_data  = {bus.mov_data,  bus.fpu_data,  bus.alu_data,  bus.uart_data};

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    wb_slot #(.XLEN(XLEN), .AW(AW)) u_slot (
      .clk   (clk),
      .rstn  (rstn),
      .valid (s_valid[i]),
      .addr  (s_addr[i]),
      .data  (s_data[i]),
      .clr   (s_clr[i]),
      .ready (s_ready[i]),
      .req   (s_req[i])
    );
  end

  assign bus.uart_ready = s_ready[SLOT_UART];
  assign bus.alu_ready  = s_ready[SLOT_ALU];
  assign bus.fpu_ready  = s_ready[SLOT_FPU];
  assign bus.mov_ready  = s_ready[SLOT_MOV];

  // ---------------- load tracker ----------------
  ld_state_e       ld_state_q, ld_state_d;
  logic            ld_fpr_q,   ld_fpr_d;
  logic [AW-1:0]   ld_addr_q,  ld_addr_d;
  logic [XLEN-1:0] ld_data_q,  ld_data_d;
  logic            ld_err_q,   ld_err_d;
  logic            ld_grant;

  always_comb begin
    ld_state_d = ld_state_q;
    ld_fpr_d   = ld_fpr_q;
    ld_addr_d  = ld_addr_q;
    ld_data_d  = ld_data_q;
    ld_err_d   = ld_err_q;
    // Out-of-protocol events are dropped; only the sticky flag records them.
    if (bus.ld_issue    && ld_state_q != LD_IDLE) ld_err_d = 1'b1;
    if (bus.load_finish && ld_state_q != LD_WAIT) ld_err_d = 1'b1;
    case (ld_state_q)
      LD_IDLE: if (bus.ld_issue) begin
        ld_state_d = LD_WAIT;
        ld_fpr_d   = bus.ld_fpr;
        ld_addr_d  = bus.ld_addr;
      end
      LD_WAIT: if (bus.load_finish) begin
        ld_state_d = LD_FULL;
        ld_data_d  = bus.rdata;
      end
      LD_FULL: if (ld_grant) ld_state_d = LD_IDLE;
      default: ld_state_d = LD_IDLE;
    endcase
  end

  assign bus.ld_busy = (ld_state_q != LD_IDLE);
  assign bus.ld_err  = ld_err_q;

  // ---------------- arbitration ----------------
  wb_req_t ld_req, g_win, f_win;
  wb_src_e g_src, f_src;

  assign ld_req = '{full: (ld_state_q == LD_FULL), addr: ld_addr_q, data: ld_data_q};

  always_comb begin
    g_win = '0;
    g_src = SRC_LOAD;
    if (ld_req.full && !ld_fpr_q) begin
      g_win = ld_req;               g_src = SRC_LOAD;
    end else if (s_req[SLOT_UART].full) begin
      g_win = s_req[SLOT_UART];     g_src = SRC_UART;
    end else if (s_req[SLOT_ALU].full) begin
      g_win = s_req[SLOT_ALU];      g_src = SRC_ALU;
    end
  end

  always_comb begin
    f_win = '0;
    f_src = SRC_LOAD;
    if (ld_req.full && ld_fpr_q) begin
      f_win = ld_req;               f_src = SRC_LOAD;
    end else if (s_req[SLOT_FPU].full) begin
      f_win = s_req[SLOT_FPU];      f_src = SRC_FPU;
    end else if (s_req[SLOT_MOV].full) begin
      f_win = s_req[SLOT_MOV];      f_src = SRC_MOV;
    end
  end

  always_comb begin
    s_clr            = '0;
    s_clr[SLOT_UART] = g_win.full && (g_src == SRC_UART);
    s_clr[SLOT_ALU]  = g_win.full && (g_src == SRC_ALU);
    s_clr[SLOT_FPU]  = f_win.full && (f_src == SRC_FPU);
    s_clr[SLOT_MOV]  = f_win.full && (f_src == SRC_MOV);
    ld_grant         = (g_win.full && (g_src == SRC_LOAD)) ||
                       (f_win.full && (f_src == SRC_LOAD));
  end

  // ---------------- registered write ports ----------------
  logic            gpr_we_q, gpr_we_d, gpr_fin_q, gpr_fin_d;
  logic            fpr_we_q, fpr_we_d, fpr_fin_q, fpr_fin_d;
  logic [AW-1:0]   gpr_waddr_q, gpr_waddr_d, fpr_waddr_q, fpr_waddr_d;
  logic [XLEN-1:0] gpr_wdata_q, gpr_wdata_d, fpr_wdata_q, fpr_wdata_d;

  always_comb begin
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    fpr_waddr_d = fpr_waddr_q;
    fpr_wdata_d = fpr_wdata_q;
    // A grant to GPR r0 still completes (finish pulse, slot frees) but never
    // reaches the register file.
    gpr_fin_d   = g_win.full;
    gpr_we_d    = g_win.full && (g_win.addr != GPR_ZERO);
    fpr_fin_d   = f_win.full;
    fpr_we_d    = f_win.full;
    if (g_win.full) begin
      gpr_waddr_d = g_win.addr;
      gpr_wdata_d = g_win.data;
    end
    if (f_win.full) begin
      fpr_waddr_d = f_win.addr;
      fpr_wdata_d = f_win.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_state_q  <= LD_IDLE;
      ld_fpr_q    <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      ld_err_q    <= 1'b0;
      gpr_we_q    <= 1'b0;
      gpr_fin_q   <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
      fpr_we_q    <= 1'b0;
      fpr_fin_q   <= 1'b0;
      fpr_waddr_q <= '0;
      fpr_wdata_q <= '0;
    end else begin
      ld_state_q  <= ld_state_d;
      ld_fpr_q    <= ld_fpr_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      ld_err_q    <= ld_err_d;
      gpr_we_q    <= gpr_we_d;
      gpr_fin_q   <= gpr_fin_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
      fpr_we_q    <= fpr_we_d;
      fpr_fin_q   <= fpr_fin_d;
      fpr_waddr_q <= fpr_waddr_d;
      fpr_wdata_q <= fpr_wdata_d;
    end
  end

  assign bus.gpr_we      = gpr_we_q;
  assign bus.gpr_waddr   = gpr_waddr_q;
  assign bus.gpr_wdata   = gpr_wdata_q;
  assign bus.wgpr_finish = gpr_fin_q;
  assign bus.fpr_we      = fpr_we_q;
  assign bus.fpr_waddr   = fpr_waddr_q;
  assign bus.fpr_wdata   = fpr_wdata_q;
  assign bus.wfpr_finish = fpr_fin_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// transaction-level model checked against the DUT every cycle.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk, rstn;
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();
  wb_arbiter #(.XLEN(32), .AW(5)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- model ----------------
  // Index 0 is the returned-load entry, 1..4 the uart/alu/fpu/mov requests.
  localparam int L = int'(SRC_LOAD), U = int'(SRC_UART), A = int'(SRC_ALU);
  localparam int F = int'(SRC_FPU),  M = int'(SRC_MOV);
  bit          m_full [5];
  logic [4:0]  m_addr [5];
  logic [31:0] m_data [5];
  bit          m_out, m_lfpr, m_err;   // m_out: issued, data not yet back
  logic        e_gwe, e_gfin, e_fwe, e_ffin;
  logic [4:0]  e_ga, e_fa;
  logic [31:0] e_gd, e_fd;

  always @(posedge clk) begin : mdl
    int gw, fw;
    bit was_idle, was_wait;
    bit          v [5];
    logic [4:0]  ia [5];
    logic [31:0] id [5];
    bit          cap [5];
    int gpr_order [3];
    int fpr_order [3];
    v  = '{0, bus.uart_valid, bus.alu_valid, bus.fpu_valid, bus.mov_valid};
    ia = '{5'd0, bus.uart_addr, bus.alu_addr, bus.fpu_addr, bus.mov_addr};
    id = '{32'd0, bus.uart_data, bus.alu_data, bus.fpu_data, bus.mov_data};
    gpr_order = '{L, U, A};
    fpr_order = '{L, F, M};
    if (!rstn) begin
      for (int i = 0; i < 5; i++) begin m_full[i] = 0; m_addr[i] = 0; m_data[i] = 0; end
      m_out = 0; m_lfpr = 0; m_err = 0;
      e_gwe = 0; e_gfin = 0; e_fwe = 0; e_ffin = 0;
      e_ga = 0; e_fa = 0; e_gd = 0; e_fd = 0;
    end else begin
      gw = -1; fw = -1;
      for (int k = 2; k >= 0; k--) begin
        if (m_full[gpr_order[k]] && (gpr_order[k] != L || !m_lfpr)) gw = gpr_order[k];
        if (m_full[fpr_order[k]] && (fpr_order[k] != L ||  m_lfpr)) fw = fpr_order[k];
      end
      e_gfin = (gw >= 0);
      e_gwe  = (gw >= 0) && (m_addr[gw] != 0);
      if (gw >= 0) begin e_ga = m_addr[gw]; e_gd = m_data[gw]; end
      e_ffin = (fw >= 0);
      e_fwe  = (fw >= 0);
      if (fw >= 0) begin e_fa = m_addr[fw]; e_fd = m_data[fw]; end
      was_idle = !m_out && !m_full[L];
      was_wait = m_out;
      if (bus.ld_issue && !was_idle)    m_err = 1;
      if (bus.load_finish && !was_wait) m_err = 1;
      for (int s = 1; s < 5; s++) cap[s] = v[s] && !m_full[s];
      if (gw >= 0) m_full[gw] = 0;
      if (fw >= 0) m_full[fw] = 0;
      for (int s = 1; s < 5; s++)
        if (cap[s]) begin m_full[s] = 1; m_addr[s] = ia[s]; m_data[s] = id[s]; end
      if (bus.ld_issue && was_idle) begin m_out = 1; m_lfpr = bus.ld_fpr; m_addr[L] = bus.ld_addr; end
      if (bus.load_finish && was_wait) begin m_out = 0; m_full[L] = 1; m_data[L] = bus.rdata; end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_uart_ready", bus.uart_ready, !m_full[U]);
      chk("m_alu_ready",  bus.alu_ready,  !m_full[A]);
      chk("m_fpu_ready",  bus.fpu_ready,  !m_full[F]);
      chk("m_mov_ready",  bus.mov_ready,  !m_full[M]);
      chk("m_ld_busy",    bus.ld_busy,    m_out || m_full[L]);
      chk("m_ld_err",     bus.ld_err,     m_err);
      chk("m_gpr_we",     bus.gpr_we,     e_gwe);
      chk("m_gpr_fin",    bus.wgpr_finish, e_gfin);
      chk("m_gpr_waddr",  bus.gpr_waddr,  e_ga);
      chk("m_gpr_wdata",  bus.gpr_wdata,  e_gd);
      chk("m_fpr_we",     bus.fpr_we,     e_fwe);
      chk("m_fpr_fin",    bus.wfpr_finish, e_ffin);
      chk("m_fpr_waddr",  bus.fpr_waddr,  e_fa);
      chk("m_fpr_wdata",  bus.fpr_wdata,  e_fd);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rstn = 0;
    bus.alu_valid = 0;  bus.alu_addr = 0;  bus.alu_data = 0;
    bus.uart_valid = 0; bus.uart_addr = 0; bus.uart_data = 0;
    bus.fpu_valid = 0;  bus.fpu_addr = 0;  bus.fpu_data = 0;
    bus.mov_valid = 0;  bus.mov_addr = 0;  bus.mov_data = 0;
    bus.ld_issue = 0; bus.ld_fpr = 0; bus.ld_addr = 0; bus.load_finish = 0; bus.rdata = 0;
    repeat (2) tick();
    chk("rst_alu_ready", bus.alu_ready, 1);
    chk("rst_mov_ready", bus.mov_ready, 1);
    chk("rst_ld_busy",   bus.ld_busy, 0);
    chk("rst_ld_err",    bus.ld_err, 0);
    chk("rst_gpr_we",    bus.gpr_we, 0);
    chk("rst_fpr_fin",   bus.wfpr_finish, 0);
    chk("rst_gpr_waddr", bus.gpr_waddr, 0);
    rstn = 1; chk_on = 1;
    tick();

    // single ALU write, two-cycle latency
    bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'hDEADBEEF;
    tick(); bus.alu_valid = 0;
    chk("t1_alu_ready_low", bus.alu_ready, 0);
    chk("t1_gpr_we_early",  bus.gpr_we, 0);
    tick();
    chk("t1_gpr_we",    bus.gpr_we, 1);
    chk("t1_gpr_waddr", bus.gpr_waddr, 5);
    chk("t1_gpr_wdata", bus.gpr_wdata, 32'hDEADBEEF);
    chk("t1_gpr_fin",   bus.wgpr_finish, 1);
    chk("t1_alu_ready", bus.alu_ready, 1);
    tick();
    chk("t1_gpr_we_off", bus.gpr_we, 0);
    chk("t1_waddr_hold", bus.gpr_waddr, 5);

    // uart beats alu
    bus.uart_valid = 1; bus.uart_addr = 3; bus.uart_data = 32'h11;
    bus.alu_valid  = 1; bus.alu_addr  = 4; bus.alu_data  = 32'h22;
    tick(); bus.uart_valid = 0; bus.alu_valid = 0;
    tick();
    chk("t2_first_waddr", bus.gpr_waddr, 3);
    chk("t2_first_wdata", bus.gpr_wdata, 32'h11);
    chk("t2_alu_waiting", bus.alu_ready, 0);
    tick();
    chk("t2_second_waddr", bus.gpr_waddr, 4);
    chk("t2_second_wdata", bus.gpr_wdata, 32'h22);
    chk("t2_second_fin",   bus.wgpr_finish, 1);
    tick();
    chk("t2_fin_off", bus.wgpr_finish, 0);

    // FPR load beats a simultaneously-ready fpu request
    bus.ld_issue = 1; bus.ld_fpr = 1; bus.ld_addr = 7;
    tick(); bus.ld_issue = 0;
    chk("t3_busy_wait", bus.ld_busy, 1);
    bus.load_finish = 1; bus.rdata = 32'h3F800000;
    bus.fpu_valid = 1; bus.fpu_addr = 2; bus.fpu_data = 32'h40000000;
    tick(); bus.load_finish = 0; bus.fpu_valid = 0;
    chk("t3_busy_full", bus.ld_busy, 1);
    tick();
    chk("t3_ld_waddr", bus.fpr_waddr, 7);
    chk("t3_ld_wdata", bus.fpr_wdata, 32'h3F800000);
    chk("t3_ld_we",    bus.fpr_we, 1);
    chk("t3_busy_off", bus.ld_busy, 0);
    chk("t3_fpu_held", bus.fpu_ready, 0);
    tick();
    chk("t3_fpu_waddr", bus.fpr_waddr, 2);
    chk("t3_fpu_wdata", bus.fpr_wdata, 32'h40000000);
    tick();

    // GPR r0 write is suppressed; FPR f0 is ordinary
    bus.alu_valid = 1; bus.alu_addr = 0; bus.alu_data = 32'h1234;
    bus.mov_valid = 1; bus.mov_addr = 0; bus.mov_data = 32'h55;
    tick(); bus.alu_valid = 0; bus.mov_valid = 0;
    tick();
    chk("t4_gpr_we_zero", bus.gpr_we, 0);
    chk("t4_gpr_fin",     bus.wgpr_finish, 1);
    chk("t4_alu_ready",   bus.alu_ready, 1);
    chk("t4_fpr_we",      bus.fpr_we, 1);
    chk("t4_fpr_wdata",   bus.fpr_wdata, 32'h55);
    tick();

    // protocol errors: finish while idle, issue while waiting
    chk("t5_err_clear", bus.ld_err, 0);
    bus.load_finish = 1; bus.rdata = 32'hBAD;
    tick(); bus.load_finish = 0;
    chk("t5_err_set",   bus.ld_err, 1);
    chk("t5_still_idle", bus.ld_busy, 0);
    bus.ld_issue = 1; bus.ld_fpr = 0; bus.ld_addr = 12;
    tick(); bus.ld_fpr = 1; bus.ld_addr = 9;
    tick(); bus.ld_issue = 0;
    bus.load_finish = 1; bus.rdata = 32'hCAFEF00D;
    tick(); bus.load_finish = 0;
    tick();
    chk("t5_ld_gpr_we",  bus.gpr_we, 1);
    chk("t5_ld_waddr",   bus.gpr_waddr, 12);
    chk("t5_ld_wdata",   bus.gpr_wdata, 32'hCAFEF00D);
    chk("t5_no_fpr",     bus.fpr_we, 0);
    chk("t5_err_sticky", bus.ld_err, 1);
    tick();

    // contention burst: every source held valid, a GPR load in the middle
    for (int i = 0; i < 14; i++) begin
      bus.uart_valid = 1; bus.uart_addr = 5'(i + 1);  bus.uart_data = 32'h1000 + i;
      bus.alu_valid  = 1; bus.alu_addr  = 5'(i);      bus.alu_data  = 32'h2000 + i;
      bus.fpu_valid  = (i % 3) != 0; bus.fpu_addr = 5'(20 + i); bus.fpu_data = 32'h3000 + i;
      bus.mov_valid  = 1; bus.mov_addr  = 5'(i);      bus.mov_data  = 32'h4000 + i;
      bus.ld_issue    = (i == 2); bus.ld_fpr = 0; bus.ld_addr = 5'd17;
      bus.load_finish = (i == 5); bus.rdata  = 32'h5000 + i;
      tick();
    end
    bus.uart_valid = 0; bus.alu_valid = 0; bus.fpu_valid = 0; bus.mov_valid = 0;
    bus.ld_issue = 0; bus.load_finish = 0;
    repeat (6) tick();

    // reset discards a full slot and an outstanding load
    bus.uart_valid = 1; bus.uart_addr = 6; bus.uart_data = 32'h77;
    bus.ld_issue = 1; bus.ld_fpr = 0; bus.ld_addr = 8;
    tick(); bus.uart_valid = 0; bus.ld_issue = 0;
    chk("t7_uart_full", bus.uart_ready, 0);
    chk("t7_busy",      bus.ld_busy, 1);
    rstn = 0;
    tick(); rstn = 1;
    chk("t7_uart_ready", bus.uart_ready, 1);
    chk("t7_busy_off",   bus.ld_busy, 0);
    chk("t7_err_off",    bus.ld_err, 0);
    chk("t7_gpr_fin",    bus.wgpr_finish, 0);
    repeat (2) begin
      tick();
      chk("t7_no_we",  bus.gpr_we, 0);
      chk("t7_no_fin", bus.wgpr_finish, 0);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
